// File: rtl/uart_rx_mmr_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register offsets,
// status bit positions, bit-timing FSM states and the STATUS word builder.
package uart_rx_mmr_pkg;

   localparam logic [31:0] UART_RX_DATA_OFF = 32'd0;
   localparam logic [31:0] UART_RX_STAT_OFF = 32'd1;

   localparam int STAT_NONEMPTY = 0;
   localparam int STAT_FULL     = 1;
   localparam int STAT_OVR      = 2;
   localparam int STAT_FERR     = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

   function automatic logic [31:0] status_word(input logic ferr, input logic ovr,
                                               input logic full, input logic nonempty);
      logic [31:0] w;
      w                = '0;
      w[STAT_FERR]     = ferr;
      w[STAT_OVR]      = ovr;
      w[STAT_FULL]     = full;
      w[STAT_NONEMPTY] = nonempty;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with power-of-two depth; full/empty come from comparing
// pointers that carry one extra wrap bit.
module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 3,
   parameter int WIDTH      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PW = DEPTH_LOG2 + 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                    (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
   assign dout_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_pop   = pop_i && !empty_o;
   assign do_push  = push_i && (!full_o || do_pop);
   assign wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
   assign rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         // NOTE: non-blocking so every register updates from pre-edge values.
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din_i;
   end

endmodule

// File: rtl/uart_rx_mmr.sv
// Memory-mapped 8N1 UART receiver: synchronises rxd, times bits from the
// detected start edge, queues bytes and exposes DATA/STATUS on the operand bus.
module uart_rx_mmr
   import uart_rx_mmr_pkg::*;
#(
   parameter logic [31:0] BASE         = 32'h200,
   parameter logic [15:0] CLKS_PER_BIT = 16'd434,
   parameter int          FIFO_LOG2    = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        rw,
   input  logic [31:0] addr,
   inout  wire  [31:0] data,
   input  logic        rxd,
   output logic        irq
);
   logic        sync1_q, sync2_q, rx_s;
   logic [1:0]  sync_vld_q;
   rx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        armed_q, armed_d;
   logic        expired, frame_ok, frame_bad;
   logic        ovr_q, ferr_q, irq_q;
   logic        fifo_full, fifo_empty, push, pop;
   logic [7:0]  head;
   logic        data_sel, stat_sel, rd_en, stat_wr;
   logic [31:0] rdata;
   logic        unused_wdata;

   assign rx_s = sync2_q;

   // sync_vld_q keeps the synchroniser's reset value from counting as a real idle level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         sync_vld_q <= 2'b00;
      end else begin
         sync1_q    <= rxd;
         sync2_q    <= sync1_q;
         sync_vld_q <= {sync_vld_q[0], 1'b1};
      end
   end

   assign expired = (cnt_q == 16'd1);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      armed_d   = armed_q;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!armed_q) begin
               armed_d = rx_s && sync_vld_q[1];
            end else if (!rx_s) begin
               armed_d = 1'b0;
               cnt_d   = CLKS_PER_BIT >> 1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (!expired) begin
               cnt_d = cnt_q - 16'd1;
            end else if (!rx_s) begin
               cnt_d     = CLKS_PER_BIT;
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (!expired) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = CLKS_PER_BIT;
               if (bit_idx_q == 3'd7) state_d = ST_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end
         end
         ST_STOP: begin
            if (!expired) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               frame_ok  = rx_s;
               frame_bad = !rx_s;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         armed_q   <= armed_d;
      end
   end

   assign data_sel = enable && (addr == BASE + UART_RX_DATA_OFF);
   assign stat_sel = enable && (addr == BASE + UART_RX_STAT_OFF);
   assign rd_en    = !rw && (data_sel || stat_sel);
   assign stat_wr  = rw && stat_sel;
   assign pop      = data_sel && !rw && !fifo_empty;
   assign push     = frame_ok;

   uart_rx_fifo #(
      .DEPTH_LOG2(FIFO_LOG2),
      .WIDTH     (8)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (reset_n),
      .push_i (push),
      .pop_i  (pop),
      .din_i  (shift_q),
      .dout_o (head),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );

   // A new flag event beats a write-1-to-clear landing in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovr_q  <= 1'b0;
         ferr_q <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         ovr_q  <= (frame_ok && fifo_full && !pop) || (ovr_q && !(stat_wr && data[STAT_OVR]));
         ferr_q <= frame_bad || (ferr_q && !(stat_wr && data[STAT_FERR]));
         irq_q  <= !fifo_empty;
      end
   end

   assign rdata = data_sel ? (fifo_empty ? 32'h0 : {24'h0, head})
                           : status_word(ferr_q, ovr_q, fifo_full, !fifo_empty);
   assign data  = rd_en ? rdata : {32{1'bz}};
   assign irq   = irq_q;

   assign unused_wdata = ^{data[31:4], data[1:0]};

endmodule

// File: tb/tb_uart_rx_mmr.sv
// Bench for uart_rx_mmr: queue-based model of received bytes and sticky flags,
// compared against irq and the operand bus on every falling clock edge.
module tb_uart_rx_mmr;
   localparam logic [31:0] BASE  = 32'h200;
   localparam int          CPB   = 16;
   localparam int          DEPTH = 8;
   // Edges from launching the start bit to the stop-bit sample: 2 sync flops,
   // 1 detect, half a bit to the start centre, then 9 full bits.
   localparam int          FRAME_DONE = 3 + CPB/2 + 9*CPB;
   localparam logic [31:0] FLOAT = 32'hFFFF_FFFF;

   typedef struct {
      int         edge_n;
      logic [7:0] b;
      bit         stop;
   } frame_ev_t;

   logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, rw = 1'b0, rxd = 1'b1;
   logic [31:0] addr = '0, tb_wdata = '0;
   logic        tb_drive = 1'b0;
   wire  [31:0] data_w;
   logic        irq;
   int          checks = 0, failures = 0;
   int          cyc = 0;

   logic [7:0]  mq[$];
   frame_ev_t   evq[$];
   bit          m_ovr = 0, m_ferr = 0, m_irq = 0;

   assign data_w = tb_drive ? tb_wdata : {32{1'bz}};
   for (genvar gi = 0; gi < 32; gi++) begin : g_pull
      pullup (data_w[gi]);
   end

   uart_rx_mmr #(.BASE(BASE), .CLKS_PER_BIT(16'(CPB)), .FIFO_LOG2(3)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .rw(rw), .addr(addr),
      .data(data_w), .rxd(rxd), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one update per rising edge from the bench's own stimulus.
   always @(negedge reset_n) begin
      mq.delete(); evq.delete();
      m_ovr = 0; m_ferr = 0; m_irq = 0;
   end

   always @(posedge clk) begin
      frame_ev_t ev;
      bit pop, wr_stat, was_nonempty, do_push, set_ovr, set_ferr;
      cyc = cyc + 1;
      if (!reset_n) begin
         mq.delete(); evq.delete();
         m_ovr = 0; m_ferr = 0; m_irq = 0;
      end else begin
         was_nonempty = (mq.size() != 0);
         pop      = enable && !rw && addr == BASE && was_nonempty;
         wr_stat  = enable && rw && addr == BASE + 1;
         do_push  = 0; set_ovr = 0; set_ferr = 0;
         if (evq.size() != 0 && evq[0].edge_n == cyc) begin
            ev = evq.pop_front();
            if (!ev.stop)                          set_ferr = 1;
            else if (mq.size() == DEPTH && !pop)   set_ovr  = 1;
            else                                   do_push  = 1;
         end
         if (pop)     void'(mq.pop_front());
         if (do_push) mq.push_back(ev.b);
         m_ovr  = set_ovr  || (m_ovr  && !(wr_stat && tb_wdata[2]));
         m_ferr = set_ferr || (m_ferr && !(wr_stat && tb_wdata[3]));
         m_irq  = was_nonempty;
      end
   end

   always @(negedge clk) begin
      logic [31:0] exp_bus;
      check("irq", {31'b0, irq}, {31'b0, m_irq});
      if (!tb_drive) begin
         if (reset_n && enable && !rw && addr == BASE)
            exp_bus = (mq.size() != 0) ? {24'b0, mq[0]} : 32'h0;
         else if (reset_n && enable && !rw && addr == BASE + 1)
            exp_bus = {28'b0, m_ferr, m_ovr, mq.size() == DEPTH, mq.size() != 0};
         else
            exp_bus = FLOAT;
         check("bus", data_w, exp_bus);
      end
   end

   task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
      @(posedge clk); #1;
      enable = 1; rw = 0; addr = a;
      @(negedge clk); v = data_w;
      @(posedge clk); #1;
      enable = 0; addr = '0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      enable = 1; rw = 1; addr = a; tb_wdata = d; tb_drive = 1;
      @(posedge clk); #1;
      enable = 0; rw = 0; addr = '0; tb_drive = 0;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop);
      frame_ev_t ev;
      @(posedge clk); #1;
      ev.edge_n = cyc + FRAME_DONE; ev.b = b; ev.stop = stop;
      evq.push_back(ev);
      rxd = 0;
      repeat (CPB) @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(posedge clk); #1;
      end
      rxd = stop;
      repeat (CPB) @(posedge clk); #1;
      rxd = 1;
   endtask

   task automatic expect_read(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] v;
      bus_read(a, v);
      check(name, v, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int tgt;
      logic [31:0] v;
      repeat (3) @(posedge clk); #1;
      reset_n = 1;
      repeat (4) @(posedge clk); #1;
      expect_read("reset_status", BASE + 1, 32'h0);
      expect_read("empty_data_read", BASE, 32'h0);

      // Single frame
      send_frame(8'hA5, 1);
      expect_read("single_status", BASE + 1, 32'h1);
      check("single_irq", {31'b0, irq}, 32'h1);
      expect_read("single_data", BASE, 32'hA5);
      expect_read("single_status_after", BASE + 1, 32'h0);
      check("single_irq_after", {31'b0, irq}, 32'h0);

      // Nine back-to-back frames into a depth-8 FIFO
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1);
      expect_read("b2b_status", BASE + 1, 32'h7);
      for (int i = 1; i <= 8; i++) expect_read("b2b_data", BASE, 32'(i));
      expect_read("b2b_status_drained", BASE + 1, 32'h4);
      bus_write(BASE + 1, 32'h4);
      expect_read("b2b_ovr_cleared", BASE + 1, 32'h0);

      // Framing error
      send_frame(8'h3C, 0);
      expect_read("ferr_status", BASE + 1, 32'h8);
      bus_write(BASE + 1, 32'h8);
      expect_read("ferr_cleared", BASE + 1, 32'h0);

      // Start-bit glitch shorter than half a bit
      @(posedge clk); #1; rxd = 0;
      repeat (4) @(posedge clk); #1; rxd = 1;
      repeat (2*CPB) @(posedge clk); #1;
      expect_read("glitch_status", BASE + 1, 32'h0);
      send_frame(8'h5A, 1);
      expect_read("glitch_next_data", BASE, 32'h5A);

      // Push and pop on the same edge with the FIFO full
      for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1);
      expect_read("pp_full_status", BASE + 1, 32'h3);
      fork
         send_frame(8'h18, 1);
         begin
            @(posedge clk); #1;
            tgt = cyc + FRAME_DONE;
            while (cyc < tgt - 1) begin @(posedge clk); #1; end
            enable = 1; rw = 0; addr = BASE;
            @(negedge clk); v = data_w;
            @(posedge clk); #1;
            enable = 0; addr = '0;
            check("pp_pop_data", v, 32'h10);
         end
      join
      expect_read("pp_status", BASE + 1, 32'h3);
      for (int i = 1; i <= 8; i++) expect_read("pp_drain", BASE, 32'h10 + 32'(i));
      expect_read("pp_empty", BASE + 1, 32'h0);

      // Reset during data bit 3 while the line is held low
      @(posedge clk); #1; rxd = 0;
      repeat (4*CPB + CPB/2) @(posedge clk); #1;
      reset_n = 0;
      repeat (3) @(posedge clk); #1;
      reset_n = 1;
      repeat (2*CPB) @(posedge clk); #1;
      rxd = 1;
      repeat (CPB) @(posedge clk); #1;
      expect_read("rst_status_idle", BASE + 1, 32'h0);
      send_frame(8'h81, 1);
      expect_read("rst_status", BASE + 1, 32'h1);
      expect_read("rst_unmapped_float", BASE + 2, FLOAT);
      expect_read("rst_data", BASE, 32'h81);
      expect_read("rst_status_after", BASE + 1, 32'h0);
      @(negedge clk);
      check("no_enable_float", data_w, FLOAT);

      repeat (4) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
